// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: funct3 access codes,
// FSM states and requester identity.
package mem_arb_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// Byte-lane alignment for the load/store path: store lane steering and
// error detection on the request side, load extraction and extension on return.
module lsu_align
    import mem_arb_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  f3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        err,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata_in,
    output logic [31:0] rdata
);

    logic        misalign;
    logic        bad_f3;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        case (f3)
            F3_B: begin
                be    = 4'b0001 << off;
                wdata = {4{wdata_in[7:0]}};
            end
            F3_H: begin
                be    = 4'b0011 << off;
                wdata = {2{wdata_in[15:0]}};
            end
            F3_W: begin
                be    = 4'b1111;
                wdata = wdata_in;
            end
            default: ;
        endcase
    end

    always_comb begin
        misalign = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        if (is_store)
            bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
        else
            bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        err = misalign || bad_f3;
    end

    always_comb begin
        byte_v = rdata_in[{ld_off, 3'b000} +: 8];
        half_v = ld_off[1] ? rdata_in[31:16] : rdata_in[15:0];
        rdata  = 32'h0;
        case (ld_f3)
            F3_B:    rdata = {{24{byte_v[7]}}, byte_v};
            F3_H:    rdata = {{16{half_v[15]}}, half_v};
            F3_W:    rdata = rdata_in;
            F3_BU:   rdata = {24'h0, byte_v};
            F3_HU:   rdata = {16'h0, half_v};
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word memory between instruction fetch and load/store:
// fair arbitration, a two-state issue/ack FSM and load/store lane alignment.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    output logic              i_err,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [2:0]        d_funct3,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t state, state_next;
    owner_t owner;
    logic        last_data;
    logic [1:0]  cap_off;
    logic [2:0]  cap_f3;
    logic        cap_err;
    logic        cap_store;

    logic              d_req;
    logic              grant_data;
    logic              grant_fetch;
    logic              issue;
    logic              issue_err;
    logic [MEM_AW+1:0] sel_addr;
    logic              busy;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic              al_err;
    logic [31:0]       al_rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[31:MEM_AW+2], d_addr[31:MEM_AW+2]};

    // Data wins unless the previous grant was data and a fetch is waiting.
    assign d_req       = d_rd | d_wr;
    assign grant_data  = d_req & (~i_req | ~last_data);
    assign grant_fetch = ~grant_data & i_req;
    assign issue       = (state == ST_IDLE) & (grant_data | grant_fetch) & ~rst;
    assign sel_addr    = grant_data ? d_addr[MEM_AW+1:0] : i_addr[MEM_AW+1:0];
    assign issue_err   = grant_data ? (al_err | (d_rd & d_wr)) : (i_addr[1:0] != 2'b00);

    lsu_align u_align (
        .is_store (d_wr),
        .f3       (d_funct3),
        .off      (d_addr[1:0]),
        .wdata_in (d_wdata),
        .be       (al_be),
        .wdata    (al_wdata),
        .err      (al_err),
        .ld_f3    (cap_f3),
        .ld_off   (cap_off),
        .rdata_in (mem_rdata),
        .rdata    (al_rdata)
    );

    // Errored requests still take both cycles but never touch the memory.
    assign mem_en    = issue & ~issue_err;
    assign mem_we    = mem_en & grant_data & d_wr;
    assign mem_be    = mem_we ? al_be : 4'b0000;
    assign mem_wdata = mem_we ? al_wdata : 32'h0;
    assign mem_addr  = mem_en ? sel_addr[MEM_AW+1:2] : '0;

    assign busy    = (state == ST_BUSY) & ~rst;
    assign i_ack   = busy & (owner == OWN_FETCH);
    assign d_ack   = busy & (owner == OWN_DATA);
    assign i_err   = i_ack & cap_err;
    assign d_err   = d_ack & cap_err;
    assign i_rdata = (i_ack & ~cap_err) ? mem_rdata : 32'h0;
    assign d_rdata = (d_ack & ~cap_err & ~cap_store) ? al_rdata : 32'h0;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_data | grant_fetch) state_next = ST_BUSY;
            ST_BUSY: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_FETCH;
            last_data <= 1'b0;
            cap_off   <= 2'b00;
            cap_f3    <= 3'b000;
            cap_err   <= 1'b0;
            cap_store <= 1'b0;
        end else begin
            state <= state_next;
            if (issue) begin
                owner     <= grant_data ? OWN_DATA : OWN_FETCH;
                last_data <= grant_data;
                cap_off   <= sel_addr[1:0];
                cap_f3    <= d_funct3;
                cap_err   <= issue_err;
                cap_store <= grant_data & d_wr;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of load/store transactions with
// hand-computed results, plus sequences for fetch, fairness, reset and errors.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_rd;
    logic        d_wr;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic [31:0] mem [256];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_rd      (d_rd),
        .d_wr      (d_wr),
        .d_funct3  (d_funct3),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Single-ported memory with registered read data, reading the pre-write word.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= mem[mem_addr];
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        en;
        logic        we;
        logic [3:0]  be;
        logic [31:0] mw;
        logic [7:0]  maddr;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic en, input logic we, input logic [3:0] be,
                                input logic [31:0] mw, input logic [7:0] maddr,
                                input logic err, input logic [31:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.en = en; v.we = we; v.be = be; v.mw = mw; v.maddr = maddr;
        v.err = err; v.rdata = rdata;
        return v;
    endfunction

    // Entered just after a rising edge with the FSM idle; leaves it idle again.
    task automatic run_vec(input int idx, input vec_t v);
        d_rd = v.rd; d_wr = v.wr; d_funct3 = v.f3; d_addr = v.addr; d_wdata = v.wdata;
        @(negedge clk);
        check($sformatf("v%0d issue en", idx), mem_en, v.en);
        check($sformatf("v%0d issue we", idx), mem_we, v.we);
        check($sformatf("v%0d issue be", idx), mem_be, v.be);
        check($sformatf("v%0d issue wdata", idx), mem_wdata, v.mw);
        if (v.en) check($sformatf("v%0d issue addr", idx), mem_addr, v.maddr);
        check($sformatf("v%0d issue ack", idx), d_ack, 1'b0);
        @(posedge clk); #1;
        d_rd = 1'b0; d_wr = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d ack", idx), d_ack, 1'b1);
        check($sformatf("v%0d err", idx), d_err, v.err);
        check($sformatf("v%0d rdata", idx), d_rdata, v.rdata);
        check($sformatf("v%0d ack en", idx), mem_en, 1'b0);
        check($sformatf("v%0d ack iack", idx), i_ack, 1'b0);
        @(posedge clk); #1;
    endtask

    vec_t vecs[19];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h01] = 32'h0BADF00D;
        mem[8'h04] = 32'hCAFE0004;
        mem[8'h40] = 32'h11223344;

        vecs[0]  = mk(0, 1, 3'b000, 32'h103, 32'h000000A5, 1, 1, 4'b1000, 32'hA5A5A5A5, 8'h40, 0, 32'h0);
        vecs[1]  = mk(1, 0, 3'b000, 32'h103, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h40, 0, 32'hFFFFFFA5);
        vecs[2]  = mk(1, 0, 3'b100, 32'h103, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h40, 0, 32'h000000A5);
        vecs[3]  = mk(1, 0, 3'b001, 32'h102, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h40, 0, 32'hFFFFA522);
        vecs[4]  = mk(1, 0, 3'b101, 32'h102, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h40, 0, 32'h0000A522);
        vecs[5]  = mk(0, 1, 3'b001, 32'h100, 32'h0000BEEF, 1, 1, 4'b0011, 32'hBEEFBEEF, 8'h40, 0, 32'h0);
        vecs[6]  = mk(1, 0, 3'b010, 32'h100, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h40, 0, 32'hA522BEEF);
        vecs[7]  = mk(1, 0, 3'b000, 32'h101, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h40, 0, 32'hFFFFFFBE);
        vecs[8]  = mk(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 1, 1, 4'b1111, 32'hDEADBEEF, 8'h41, 0, 32'h0);
        vecs[9]  = mk(1, 0, 3'b010, 32'h104, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h41, 0, 32'hDEADBEEF);
        vecs[10] = mk(1, 0, 3'b101, 32'h106, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h41, 0, 32'h0000DEAD);
        vecs[11] = mk(1, 0, 3'b000, 32'h107, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h41, 0, 32'hFFFFFFDE);
        vecs[12] = mk(1, 0, 3'b010, 32'h404, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h01, 0, 32'h0BADF00D);
        vecs[13] = mk(1, 0, 3'b010, 32'h006, 32'h0, 0, 0, 4'b0000, 32'h0, 8'h00, 1, 32'h0);
        vecs[14] = mk(1, 0, 3'b001, 32'h101, 32'h0, 0, 0, 4'b0000, 32'h0, 8'h00, 1, 32'h0);
        vecs[15] = mk(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 4'b0000, 32'h0, 8'h00, 1, 32'h0);
        vecs[16] = mk(0, 1, 3'b100, 32'h104, 32'h0, 0, 0, 4'b0000, 32'h0, 8'h00, 1, 32'h0);
        vecs[17] = mk(0, 1, 3'b010, 32'h105, 32'h0, 0, 0, 4'b0000, 32'h0, 8'h00, 1, 32'h0);
        vecs[18] = mk(1, 0, 3'b010, 32'h104, 32'h0, 1, 0, 4'b0000, 32'h0, 8'h41, 0, 32'hDEADBEEF);

        rst = 1'b1; i_req = 1'b1; i_addr = 32'h10; d_rd = 1'b1; d_wr = 1'b0;
        d_funct3 = 3'b010; d_addr = 32'h104; d_wdata = 32'h0;

        // Outputs held low while reset is asserted, even with requests present.
        @(negedge clk);
        check("rst mem_en", mem_en, 1'b0);
        check("rst mem_we", mem_we, 1'b0);
        check("rst mem_be", mem_be, 4'b0);
        check("rst mem_addr", mem_addr, 8'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst i_ack", i_ack, 1'b0);
        check("rst d_ack", d_ack, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; d_rd = 1'b0;

        // Fetch only, held request: one access every two cycles.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("fetch%0d en", k), mem_en, 1'b1);
            check($sformatf("fetch%0d we", k), mem_we, 1'b0);
            check($sformatf("fetch%0d addr", k), mem_addr, 8'h04);
            check($sformatf("fetch%0d early ack", k), i_ack, 1'b0);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("fetch%0d ack", k), i_ack, 1'b1);
            check($sformatf("fetch%0d rdata", k), i_rdata, 32'hCAFE0004);
            check($sformatf("fetch%0d err", k), i_err, 1'b0);
            check($sformatf("fetch%0d d_ack", k), d_ack, 1'b0);
            @(posedge clk);
        end
        #1 i_req = 1'b0;

        for (int i = 0; i < 19; i++) run_vec(i, vecs[i]);
        check("mem 0x104 untouched", mem[8'h41], 32'hDEADBEEF);

        // Misaligned fetch.
        i_req = 1'b1; i_addr = 32'h12;
        @(negedge clk);
        check("mis fetch en", mem_en, 1'b0);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        check("mis fetch ack", i_ack, 1'b1);
        check("mis fetch err", i_err, 1'b1);
        check("mis fetch rdata", i_rdata, 32'h0);
        @(posedge clk); #1;

        // Fairness: both held from reset, grants alternate D, F, D, F.
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h10;
        d_rd = 1'b1; d_funct3 = 3'b010; d_addr = 32'h104;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("fair c%0d d_ack", c), d_ack, (c % 4) == 1);
            check($sformatf("fair c%0d i_ack", c), i_ack, (c % 4) == 3);
            if ((c % 4) == 0) check($sformatf("fair c%0d addr", c), mem_addr, 8'h41);
            if ((c % 4) == 2) check($sformatf("fair c%0d addr", c), mem_addr, 8'h04);
            @(posedge clk);
        end
        #1 i_req = 1'b0; d_rd = 1'b0;

        // Reset during the ack cycle of a store, then the held store re-issues.
        d_wr = 1'b1; d_funct3 = 3'b010; d_addr = 32'h108; d_wdata = 32'h11111111;
        @(negedge clk);
        check("rstbusy issue we", mem_we, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstbusy d_ack", d_ack, 1'b0);
        check("rstbusy mem_en", mem_en, 1'b0);
        check("rstbusy mem_we", mem_we, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstbusy reissue en", mem_en, 1'b1);
        check("rstbusy reissue we", mem_we, 1'b1);
        check("rstbusy reissue addr", mem_addr, 8'h42);
        @(posedge clk); #1;
        d_wr = 1'b0;
        @(negedge clk);
        check("rstbusy ack", d_ack, 1'b1);
        check("rstbusy err", d_err, 1'b0);
        @(posedge clk); #1;
        check("rstbusy mem", mem[8'h42], 32'h11111111);

        // Illegal rd+wr: errors without a write, then an uncontested fetch is served.
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h104; d_wdata = 32'h0;
        @(negedge clk);
        check("ill en", mem_en, 1'b0);
        @(posedge clk); #1;
        d_rd = 1'b0; d_wr = 1'b0; i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        check("ill d_ack", d_ack, 1'b1);
        check("ill d_err", d_err, 1'b1);
        check("ill d_rdata", d_rdata, 32'h0);
        check("ill i_ack", i_ack, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ill fetch en", mem_en, 1'b1);
        check("ill fetch addr", mem_addr, 8'h04);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        check("ill fetch ack", i_ack, 1'b1);
        check("ill fetch rdata", i_rdata, 32'hCAFE0004);
        check("ill mem", mem[8'h41], 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
